// File: rtl/sipo_deframer.sv
// sipo_deframer: serial-in/parallel-out deserialiser with a per-bit valid
// qualifier, selectable bit order, a bit counter, a one-word holding
// register with a valid/ready handshake and sticky overflow detection.
// Every output is driven straight from a register.
module sipo_deframer #(
   parameter int DATA_WIDTH = 16,
   parameter bit MSB_FIRST  = 1'b1,
   parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  serial_in,
   input  logic                  serial_valid,
   input  logic                  sync_clear,
   output logic [DATA_WIDTH-1:0] parallel_out,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] shift_out,
   output logic [CNT_W-1:0]      bit_count,
   output logic                  overflow
);

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   logic [DATA_WIDTH-1:0] shift_reg;
   logic [DATA_WIDTH-1:0] shift_next;
   logic [CNT_W-1:0]      cnt_reg;
   logic [DATA_WIDTH-1:0] hold_reg;
   logic                  valid_reg;
   logic                  ovf_reg;
   logic                  word_done;
   logic                  hold_free;
   logic                  drain;

   // Post-shift value; the bit order only changes which end the new bit enters.
   generate
      if (MSB_FIRST) begin : g_msb_first
         assign shift_next = {shift_reg[DATA_WIDTH-2:0], serial_in};
      end else begin : g_lsb_first
         assign shift_next = {serial_in, shift_reg[DATA_WIDTH-1:1]};
      end
   endgenerate

   // Completion, holding-register availability and consumer acceptance for this edge.
   always_comb begin
      word_done = serial_valid && !sync_clear && (cnt_reg == LAST_BIT);
      drain     = valid_reg && out_ready;
      hold_free = !valid_reg || out_ready;
   end

   // Shift register and bit counter; a frame restart beats an incoming bit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shift_reg <= '0;
         cnt_reg   <= '0;
      end else if (sync_clear) begin
         shift_reg <= '0;
         cnt_reg   <= '0;
      end else if (serial_valid) begin
         shift_reg <= shift_next;
         cnt_reg   <= (cnt_reg == LAST_BIT) ? '0 : cnt_reg + CNT_W'(1);
      end
   end

   // Holding register: load on completion when free (including drain-and-refill), else drop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hold_reg  <= '0;
         valid_reg <= 1'b0;
      end else if (word_done && hold_free) begin
         hold_reg  <= shift_next;
         valid_reg <= 1'b1;
      end else if (drain) begin
         valid_reg <= 1'b0;
      end
   end

   // Sticky overflow: set when a finished word finds the holding register occupied.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ovf_reg <= 1'b0;
      end else if (sync_clear) begin
         ovf_reg <= 1'b0;
      end else if (word_done && !hold_free) begin
         ovf_reg <= 1'b1;
      end
   end

   assign parallel_out = hold_reg;
   assign out_valid    = valid_reg;
   assign shift_out    = shift_reg;
   assign bit_count    = cnt_reg;
   assign overflow     = ovf_reg;

endmodule

// File: tb/tb_sipo_deframer.sv
// Bench for sipo_deframer: directed scenarios followed by random traffic,
// all checked against a word-level reference model kept here.
module tb_sipo_deframer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        serial_in = 1'b0, serial_valid = 1'b0, sync_clear = 1'b0, out_ready = 1'b0;
   logic [15:0] parallel_out, shift_out;
   logic        out_valid, overflow;
   logic [3:0]  bit_count;

   logic        s8_in = 1'b0, s8_valid = 1'b0;
   logic [7:0]  p8l, p8m, sh8l, sh8m;
   logic        v8l, v8m, o8l, o8m;
   logic [2:0]  c8l, c8m;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state (plain integers)
   int m_shift, m_cnt, m_par, m_valid, m_ovf;

   always #5 clk = ~clk;

   sipo_deframer #(.DATA_WIDTH(16), .MSB_FIRST(1'b1)) dut (
      .clk(clk), .reset(reset), .serial_in(serial_in), .serial_valid(serial_valid),
      .sync_clear(sync_clear), .parallel_out(parallel_out), .out_valid(out_valid),
      .out_ready(out_ready), .shift_out(shift_out), .bit_count(bit_count), .overflow(overflow));

   sipo_deframer #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) dut8l (
      .clk(clk), .reset(reset), .serial_in(s8_in), .serial_valid(s8_valid),
      .sync_clear(1'b0), .parallel_out(p8l), .out_valid(v8l),
      .out_ready(1'b1), .shift_out(sh8l), .bit_count(c8l), .overflow(o8l));

   sipo_deframer #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) dut8m (
      .clk(clk), .reset(reset), .serial_in(s8_in), .serial_valid(s8_valid),
      .sync_clear(1'b0), .parallel_out(p8m), .out_valid(v8m),
      .out_ready(1'b1), .shift_out(sh8m), .bit_count(c8m), .overflow(o8m));

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_shift = 0; m_cnt = 0; m_par = 0; m_valid = 0; m_ovf = 0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ":parallel_out"}, int'(parallel_out), m_par);
      chk({tag, ":out_valid"},    int'(out_valid),    m_valid);
      chk({tag, ":shift_out"},    int'(shift_out),    m_shift);
      chk({tag, ":bit_count"},    int'(bit_count),    m_cnt);
      chk({tag, ":overflow"},     int'(overflow),     m_ovf);
   endtask

   // Word-level rules: a bit appends to the stream, every 16th bit finishes a word.
   task automatic model_edge(input int sv, input int si, input int sc, input int rdy);
      int full_before;
      full_before = m_valid && !rdy;
      if (sc) begin
         m_shift = 0; m_cnt = 0; m_ovf = 0;
         if (m_valid && rdy) m_valid = 0;
      end else if (sv && m_cnt == 15) begin
         m_shift = (m_shift * 2 + si) % 65536;
         m_cnt = 0;
         if (full_before) m_ovf = 1;
         else begin m_par = m_shift; m_valid = 1; end
      end else begin
         if (sv) begin
            m_shift = (m_shift * 2 + si) % 65536;
            m_cnt = m_cnt + 1;
         end
         if (m_valid && rdy) m_valid = 0;
      end
   endtask

   task automatic cycle(input int sv, input int si, input int sc, input int rdy, input string tag);
      serial_valid = 1'(sv); serial_in = 1'(si); sync_clear = 1'(sc); out_ready = 1'(rdy);
      @(posedge clk);
      model_edge(sv, si, sc, rdy);
      #1;
      check_all(tag);
   endtask

   // 16 bits MSB first; rdy applies to all bits but the last, which uses rdy_last
   task automatic send_word(input int w, input int gaps, input int rdy, input int rdy_last, input string tag);
      for (int i = 15; i >= 0; i--) begin
         cycle(1, (w >> i) & 1, 0, (i == 0) ? rdy_last : rdy, tag);
         if (gaps) cycle(0, 0, 0, rdy, tag);
      end
   endtask

   initial begin
      model_reset();
      #1;
      check_all("reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;

      // 1: back-to-back 0xA5C3 with consumer ready
      send_word(16'hA5C3, 0, 1, 1, "t1");
      chk("t1_word", int'(parallel_out), 16'hA5C3);
      chk("t1_valid", int'(out_valid), 1);
      chk("t1_cnt_wrap", int'(bit_count), 0);
      cycle(0, 0, 0, 1, "t1_drain");
      chk("t1_valid_clr", int'(out_valid), 0);

      // 2: same word with a gap after every bit
      send_word(16'hA5C3, 1, 1, 1, "t2");
      chk("t2_word", int'(parallel_out), 16'hA5C3);

      // 3: consumer stalled, second word overflows
      cycle(0, 0, 0, 0, "t3_idle");
      send_word(16'h1234, 0, 0, 0, "t3a");
      send_word(16'hBEEF, 0, 0, 0, "t3b");
      chk("t3_hold", int'(parallel_out), 16'h1234);
      chk("t3_valid", int'(out_valid), 1);
      chk("t3_ovf", int'(overflow), 1);
      cycle(0, 0, 0, 1, "t3_accept");
      chk("t3_valid_clr", int'(out_valid), 0);
      chk("t3_ovf_sticky", int'(overflow), 1);

      // 4: drain-and-refill on the completing edge
      cycle(0, 0, 1, 1, "t4_clear");
      send_word(16'h1111, 0, 0, 0, "t4a");
      send_word(16'h2222, 0, 0, 1, "t4b");
      chk("t4_word", int'(parallel_out), 16'h2222);
      chk("t4_valid", int'(out_valid), 1);
      chk("t4_ovf", int'(overflow), 0);

      // 5: sync_clear mid-word beats a valid bit
      for (int i = 0; i < 7; i++) cycle(1, 1, 0, 1, "t5_pre");
      cycle(1, 1, 1, 1, "t5_clear");
      chk("t5_cnt", int'(bit_count), 0);
      chk("t5_shift", int'(shift_out), 0);
      send_word(16'h00FF, 0, 1, 1, "t5");
      chk("t5_word", int'(parallel_out), 16'h00FF);

      // 6: asynchronous reset mid-word with a word pending
      for (int i = 0; i < 9; i++) cycle(1, i & 1, 0, 0, "t6_pre");
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      check_all("t6_async");
      @(negedge clk);
      reset = 1'b1;
      send_word(16'h5A5A, 0, 1, 1, "t6_post");
      chk("t6_word", int'(parallel_out), 16'h5A5A);

      // 7: 8-bit instances, bit order
      for (int i = 0; i < 8; i++) begin
         s8_in = (i == 0); s8_valid = 1'b1;
         cycle(0, 0, 0, 1, "t7_idle16");
      end
      s8_valid = 1'b0;
      chk("t7_lsb_word", int'(p8l), 8'h01);
      chk("t7_lsb_valid", int'(v8l), 1);
      chk("t7_msb_word", int'(p8m), 8'h80);
      chk("t7_msb_valid", int'(v8m), 1);

      // 8: random traffic
      for (int n = 0; n < 3000; n++) begin
         cycle(($urandom_range(0, 3) != 0) ? 1 : 0, int'($urandom_range(0, 1)),
               ($urandom_range(0, 63) == 0) ? 1 : 0,
               ($urandom_range(0, 2) != 0) ? 1 : 0, "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sipo_deframer.md
Name: sipo_deframer

Overview:
- Parametrised serial-in/parallel-out deserialiser.
- Successor to the plain free-running SIPO register. Adds:
  - a per-bit valid qualifier
  - selectable bit order
  - a word/bit counter
  - a one-word output holding register with valid/ready handshake
  - sticky overflow detection
- Sits between a serial link receiver and a word-wide downstream consumer.

Parameters:
- DATA_WIDTH, 16, word width in bits. Legal range is 2 or more.
- MSB_FIRST, 1. When 1, the first received bit lands in parallel_out[DATA_WIDTH-1]. When 0, the first received bit lands in parallel_out[0].
- CNT_W, $clog2(DATA_WIDTH), width of bit_count. Derived; not overridden.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset. 0 clears all state immediately. Release is synchronous to clk.
- serial_in  input  1  serial data bit, sampled only when serial_valid=1.
- serial_valid  input  1  qualifies serial_in on this clock edge.
- sync_clear  input  1  synchronous frame restart. Clears the partial word, bit_count and overflow.
- parallel_out  output  DATA_WIDTH  holding register: the last completed word.
- out_valid  output  1  parallel_out holds a word not yet accepted.
- out_ready  input  1  consumer accepts parallel_out when out_valid=1 and out_ready=1.
- shift_out  output  DATA_WIDTH  live view of the internal shift register (debug).
- bit_count  output  CNT_W  number of bits accumulated in the current word, range 0..DATA_WIDTH-1.
- overflow  output  1  sticky: a completed word was dropped because the holding register was full.

Behaviour:
- Reset (reset=0, asynchronous): shift_out=0, bit_count=0, parallel_out=0, out_valid=0, overflow=0.
- Shift, on an edge with serial_valid=1 and sync_clear=0:
  - MSB_FIRST=1: shift_out <= {shift_out[DATA_WIDTH-2:0], serial_in}.
  - MSB_FIRST=0: shift_out <= {serial_in, shift_out[DATA_WIDTH-1:1]}.
  - bit_count increments.
- serial_valid=0: shift_out and bit_count hold. Gaps of any length are legal.
- Word completion: an edge with serial_valid=1 and bit_count==DATA_WIDTH-1.
  - The completed word is the post-shift value.
  - bit_count wraps to 0.
  - shift_out takes the post-shift value. It is not cleared.
- Holding register is free when out_valid=0, or when out_valid=1 and out_ready=1 on the same edge (drain-and-refill).
  - On completion with the holding register free: parallel_out <= completed word and out_valid <= 1 on the same edge.
  - Latency is 0 cycles after the clock edge that samples the last bit.
- On completion with the holding register full (out_valid=1, out_ready=0):
  - The word is dropped; parallel_out and out_valid are unchanged.
  - overflow <= 1.
- Handshake:
  - out_valid=1 and out_ready=1 with no completion on that edge: out_valid <= 0, parallel_out holds its value.
  - out_ready while out_valid=0 is ignored.
  - parallel_out must remain stable while out_valid=1 and out_ready=0.
- sync_clear=1:
  - shift_out <= 0, bit_count <= 0, overflow <= 0.
  - It has priority over serial_valid on the same edge; that bit is discarded and no completion occurs.
  - parallel_out and out_valid are not affected, and the handshake still operates on that edge.
- overflow stays set until sync_clear or reset. Later successful words do not clear it.
- Reset asserted mid-word or with out_valid=1: all state is lost. No word is emitted after release. The first DATA_WIDTH valid bits after release form the next word.
- No combinational path from any input to any output. All outputs are registered.

Test Plan:
- Reset, then 16 consecutive valid bits of 0xA5C3 MSB-first, out_ready=1 → out_valid=1 and parallel_out=0xA5C3 right after the 16th edge. bit_count steps 0..15 then returns to 0. out_valid clears one edge later.
- Same word 0xA5C3 with serial_valid toggling 1/0 every cycle → identical result after 32 cycles. shift_out and bit_count hold during the 0 cycles.
- out_ready=0, send 0x1234 then 0xBEEF → parallel_out=0x1234 and out_valid=1 hold. overflow=1 after the second word's last edge. Raise out_ready → out_valid=0 next edge and overflow stays 1.
- Simultaneous events: out_valid=1 holding 0x1111, out_ready=1 on the same edge that completes 0x2222 → parallel_out=0x2222, out_valid=1, overflow=0.
- Mid-word clear and reset:
  - Send 7 bits, then sync_clear=1 with serial_valid=1 → bit_count=0, shift_out=0, bit discarded. The next 16 bits of 0x00FF yield parallel_out=0x00FF.
  - Repeat with reset pulsed low mid-cycle after 9 bits → all outputs 0 immediately, before the next edge.
- Instance with MSB_FIRST=0, DATA_WIDTH=8, bits sent in order 1,0,0,0,0,0,0,0 → parallel_out=8'h01. A DATA_WIDTH=8, MSB_FIRST=1 instance given the same stimulus → 8'h80.
